fix_to_float_serial: RTL and testbench

FIX_TO_FLOAT_SERIAL -- requirements
Module: fix_to_float_serial

---
 rtl/fix_to_float_pkg.sv | 22 ++
 rtl/fix_to_float_serial_round_pack.sv | 52 +++++
 rtl/fix_to_float_serial.sv | 113 +++++++++++
 tb/tb_fix_to_float_serial.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fix_to_float_pkg.sv
// Shared float/util package for the fixed-to-float converter.
//   - FSM state encodings for the serial converter
//   - float32_t: default output float layout {sign, exp[7:0], mant[22:0]}
//   - GetFloatExpBias: IEEE-style exponent bias for an n-bit exponent field
package fix_to_float_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_NORM  = 2'd1;
    localparam logic [1:0] ST_ROUND = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } float32_t;

    function automatic int GetFloatExpBias(input int n_exp);
        return (1 << (n_exp - 1)) - 1;
    endfunction

endpackage

// File: rtl/fix_to_float_serial_round_pack.sv
// float_round_pack: combinational rounding, exponent clamp and packing.
// Takes a normalized magnitude (MSB set) plus its leading-zero count and
// produces the packed float {sign, exp, mant}.
//   sign_i : sign of the original input
//   mag_i  : normalized magnitude, bit W-1 is the (hidden) leading one
//   lz_i   : number of left shifts applied during normalization
//   flt_o  : packed result, exponent flushed/saturated as needed
module float_round_pack
    import fix_to_float_pkg::*;
#(
    parameter int N_INT  = 8,
    parameter int W      = 32,
    parameter int LZW    = 5,
    parameter int N_EXP  = 8,
    parameter int N_MANT = 23
) (
    input  logic                   sign_i,
    input  logic [W-1:0]           mag_i,
    input  logic [LZW-1:0]         lz_i,
    output logic [N_EXP+N_MANT:0]  flt_o
);

    localparam int EXT  = W + N_MANT;
    localparam int BIAS = GetFloatExpBias(N_EXP);
    localparam int EMAX = (1 << N_EXP) - 1;
    localparam logic [N_EXP-1:0] ESAT = N_EXP'(EMAX - 1);

    // Bits below the hidden one, zero-padded so that the N_MANT mantissa bits
    // and the round bit always exist regardless of the input width.
    logic [EXT-1:0]    ext;
    logic [N_MANT-1:0] mant;
    logic              rnd;
    logic [N_MANT:0]   msum;
    int                eb;

    assign ext = {mag_i[W-2:0], {(N_MANT+1){1'b0}}};

    always_comb begin
        mant = ext[EXT-1 -: N_MANT];
        rnd  = ext[EXT-1-N_MANT];
        // Round half-up; a carry out leaves the low bits zero and bumps exp.
        msum = {1'b0, mant} + {{N_MANT{1'b0}}, rnd};
        eb   = N_INT - int'(lz_i) + BIAS + int'(msum[N_MANT]);
        if (eb <= 0)
            flt_o = '0;
        else if (eb >= EMAX)
            flt_o = {sign_i, ESAT, {N_MANT{1'b1}}};
        else
            flt_o = {sign_i, eb[N_EXP-1:0], msum[N_MANT-1:0]};
    end

endmodule

// File: rtl/fix_to_float_serial.sv
// fix_to_float_serial: converts a signed fixed-point value to a float using a
// bit-serial normalizer (one left shift per cycle) followed by a round stage.
//   clk, rst   : clock, synchronous active-high reset
//   in_data    : signed value in_data / 2^n_mant_in
//   in_valid / in_ready   : input handshake (ready only in IDLE)
//   out_data   : converted float (float_t layout {sign, exp, mant})
//   out_valid / out_ready : output handshake (valid only in DONE)
// float_t defaults to the 8/23 layout; override it together with
// n_exp_out / n_mant_out so its width stays n_exp_out+n_mant_out+1.
module fix_to_float_serial
    import fix_to_float_pkg::*;
#(
    parameter int  n_int_in   = 8,
    parameter int  n_mant_in  = 23,
    parameter int  n_exp_out  = 8,
    parameter int  n_mant_out = 23,
    parameter type float_t    = float32_t
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [n_int_in+n_mant_in:0]   in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output float_t                        out_data,
    output logic                          out_valid,
    input  logic                          out_ready
);

    localparam int W   = n_int_in + n_mant_in + 1;
    localparam int LZW = $clog2(W);
    localparam int FW  = n_exp_out + n_mant_out + 1;

    logic [1:0]     state_q, state_d;
    logic           sign_q, sign_d;
    logic [W-1:0]   mag_q, mag_d;
    logic [LZW-1:0] lz_q, lz_d;
    logic [FW-1:0]  out_q, out_d;
    logic [FW-1:0]  rounded;

    float_round_pack #(
        .N_INT  (n_int_in),
        .W      (W),
        .LZW    (LZW),
        .N_EXP  (n_exp_out),
        .N_MANT (n_mant_out)
    ) u_round (
        .sign_i (sign_q),
        .mag_i  (mag_q),
        .lz_i   (lz_q),
        .flt_o  (rounded)
    );

    // Gated by rst so the block never advertises ready while being reset.
    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = float_t'(out_q);

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        mag_d   = mag_q;
        lz_d    = lz_q;
        out_d   = out_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sign_d = in_data[W-1];
                    // Unsigned W-bit magnitude also covers the most negative value.
                    mag_d  = in_data[W-1] ? (~in_data + W'(1)) : in_data;
                    lz_d   = '0;
                    if (in_data == '0) begin
                        out_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_NORM;
                    end
                end
            end
            ST_NORM: begin
                if (mag_q[W-1]) begin
                    state_d = ST_ROUND;
                end else begin
                    mag_d = mag_q << 1;
                    lz_d  = lz_q + LZW'(1);
                end
            end
            ST_ROUND: begin
                out_d   = rounded;
                state_d = ST_DONE;
            end
            default: begin
                if (out_ready) state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sign_q  <= 1'b0;
            mag_q   <= '0;
            lz_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            mag_q   <= mag_d;
            lz_q    <= lz_d;
            out_q   <= out_d;
        end
    end

endmodule

// File: tb/tb_fix_to_float_serial.sv
module tb_fix_to_float_serial;
    import fix_to_float_pkg::*;

    typedef struct packed {
        logic        sign;
        logic [3:0]  exp;
        logic [22:0] mant;
    } f4_t;

    logic     clk = 1'b0;
    logic     rst = 1'b1;
    logic [31:0] din_a = '0, din_b = '0;
    logic     va = 1'b0, vb = 1'b0, ora = 1'b0, orb = 1'b0;
    logic     ira, irb, ova, ovb;
    float32_t out_a;
    f4_t      out_b;

    int checks = 0;
    int errors = 0;
    bit sel = 1'b0;

    always #5 clk = ~clk;

    // DUT A: default 8-bit exponent; DUT B: 4-bit exponent for clamp cases.
    fix_to_float_serial dut_a (
        .clk(clk), .rst(rst), .in_data(din_a), .in_valid(va), .in_ready(ira),
        .out_data(out_a), .out_valid(ova), .out_ready(ora)
    );

    fix_to_float_serial #(.n_exp_out(4), .float_t(f4_t)) dut_b (
        .clk(clk), .rst(rst), .in_data(din_b), .in_valid(vb), .in_ready(irb),
        .out_data(out_b), .out_valid(ovb), .out_ready(orb)
    );

    logic ov_m, ir_m, os_m;
    int   oe_m, om_m;
    assign ov_m = sel ? ovb : ova;
    assign ir_m = sel ? irb : ira;
    assign os_m = sel ? out_b.sign : out_a.sign;
    assign oe_m = sel ? int'(out_b.exp) : int'(out_a.exp);
    assign om_m = sel ? int'(out_b.mant) : int'(out_a.mant);

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: real-valued rules. value = mag * 2^-23; unbiased exponent is
    // the MSB position minus 23; mantissa rounded half-up to 23 bits.
    // Latency = edges from accept until out_valid is visible.
    function automatic void model(input logic [31:0] d, input int ne,
                                  output logic s, output int e, output int m,
                                  output int lat);
        logic [63:0] mag, t, r;
        int p, eb;
        s = 1'b0; e = 0; m = 0; lat = 0;
        if (d == 32'd0) return;
        mag = d[31] ? (64'h1_0000_0000 - {32'd0, d}) : {32'd0, d};
        p = 0;
        for (int i = 0; i < 33; i++) if (mag[i]) p = i;
        lat = (31 - p) + 2;
        t = (mag << 24) >> p;          // 1.xxx with 24 fraction bits
        r = (t + 64'd1) >> 1;          // half-up to 23 fraction bits
        eb = p - 23 + ((1 << (ne - 1)) - 1);
        if (r == (64'd1 << 24)) begin
            eb++;
            r = 64'd1 << 23;
        end
        if (eb <= 0) begin
            s = 1'b0; e = 0; m = 0;
        end else if (eb >= (1 << ne) - 1) begin
            s = d[31]; e = (1 << ne) - 2; m = (1 << 23) - 1;
        end else begin
            s = d[31]; e = eb; m = int'(r - (64'd1 << 23));
        end
    endfunction

    task automatic convert(input bit b, input logic [31:0] d, input logic es,
                           input int ee, input int em, input int elat,
                           input int stall, input string tag);
        int n;
        sel = b;
        @(negedge clk);
        chk({tag, " in_ready_idle"}, ir_m, 1);
        if (b) begin din_b = d; vb = 1'b1; end
        else   begin din_a = d; va = 1'b1; end
        @(posedge clk); #1;
        // valid stays high with junk data; it must be ignored outside IDLE
        din_a = $urandom; din_b = $urandom;
        n = 0;
        while (!ov_m && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " out_valid"}, ov_m, 1);
        chk({tag, " latency"}, n, elat);
        chk({tag, " sign"}, os_m, es);
        chk({tag, " exp"}, oe_m, ee);
        chk({tag, " mant"}, om_m, em);
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            chk({tag, " stall_valid"}, ov_m, 1);
            chk({tag, " stall_ready"}, ir_m, 0);
            chk({tag, " stall_data"}, {os_m, oe_m, om_m}, {es, ee, em});
        end
        @(negedge clk);
        va = 1'b0; vb = 1'b0;
        if (b) orb = 1'b1; else ora = 1'b1;
        @(posedge clk); #1;
        ora = 1'b0; orb = 1'b0;
        chk({tag, " valid_drop"}, ov_m, 0);
        chk({tag, " ready_back"}, ir_m, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic s;
        int e, m, lat, seen;
        logic [31:0] d;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst out_valid_a", ova, 0);
        chk("rst out_data_a", out_a, 0);
        chk("rst in_ready_a", ira, 0);
        chk("rst out_valid_b", ovb, 0);
        chk("rst in_ready_b", irb, 0);
        rst = 1'b0;
        #1;
        chk("post_rst in_ready", ira, 1);

        // Spec vectors, default format
        convert(0, 32'h0080_0000, 1'b0, 127, 0, 10, 5, "one");
        convert(0, 32'hFEC0_0000, 1'b1, 128, 32'h20_0000, 9, 0, "m2p5");
        convert(0, 32'h8000_0000, 1'b1, 135, 0, 2, 0, "min");
        convert(0, 32'h0000_0000, 1'b0, 0, 0, 0, 2, "zero");
        convert(0, 32'h7FFF_FFFF, 1'b0, 135, 0, 3, 0, "carry");
        // 4-bit exponent: flush and saturate
        convert(1, 32'h0000_0001, 1'b0, 0, 0, 33, 0, "flush4");
        convert(1, 32'h8000_0000, 1'b1, 14, 32'h7F_FFFF, 2, 0, "sat4");

        // Reset while normalizing aborts the conversion
        sel = 0;
        @(negedge clk);
        din_a = 32'h0080_0000; va = 1'b1;
        @(posedge clk); #1;
        va = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort in_ready_rst", ira, 0);
        chk("abort out_valid", ova, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort idle", ira, 1);
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (ova) seen++;
        end
        chk("abort no_valid", seen, 0);

        // Randomized against the model
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 2))
                0: d = $urandom;
                1: d = $urandom >> $urandom_range(1, 31);
                default: d = ~($urandom >> $urandom_range(1, 31));
            endcase
            model(d, 8, s, e, m, lat);
            convert(0, d, s, e, m, lat, $urandom_range(0, 2), "rand8");
        end
        for (int i = 0; i < 10; i++) begin
            d = (i % 2 == 0) ? ($urandom >> $urandom_range(20, 31)) : $urandom;
            model(d, 4, s, e, m, lat);
            convert(1, d, s, e, m, lat, 0, "rand4");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
